iir_pair_packer: RTL and testbench

Upstream feeder for the two-parallel unfolded IIR filter. It takes a serial stream of 8-bit samples with a valid/ready handshake and groups consecutive samples into even/odd pairs (x2k, x2k1). Pairs are buffered in a small FIFO and presented one pair per cycle to the filter stage. It decouples a one-sample-per-cycle source from the filter's one-pair-per-cycle consumption and adds backpressure the filter itself lacks.

---
 rtl/iir_pkg.sv | 36 +++
 rtl/iir_pair_fifo.sv | 94 +++++++++
 rtl/iir_pair_packer.sv | 118 +++++++++++
 tb/tb_iir_pair_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iir_pkg
// Description : Shared types for the two-parallel unfolded IIR datapath:
//               sample width, sample/pair types and the packer phase encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package iir_pkg;

    // Sample width shared by the packer and the filter stage
    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] sample_t;

    // One even/odd pair as consumed by the unfolded filter in a single cycle
    typedef struct packed {
        sample_t x2k;
        sample_t x2k1;
    } pair_t;

    // Packer phase: whether an even sample is waiting for its odd partner
    typedef enum logic [0:0] {
        PH_EMPTY = 1'b0,
        PH_HELD  = 1'b1
    } phase_e;

    // Builds a pair with the earlier sample in the even slot
    function automatic pair_t make_pair(input sample_t even_s, input sample_t odd_s);
        pair_t p;
        p.x2k  = even_s;
        p.x2k1 = odd_s;
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iir_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : iir_pair_fifo
// Description : Synchronous first-word-fall-through FIFO of pair_t. The head
//               is a register so it keeps its last value once the FIFO drains
//               and reads 0 after reset or flush.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_pair_fifo
    import iir_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  pair_t                    push_data,
    input  logic                     pop,
    output pair_t                    head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] c_count_full = CW'(DEPTH);
    localparam logic [CW-1:0] c_count_one  = CW'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    pair_t          r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    pair_t          r_head;

    logic           w_push;
    logic           w_pop;
    pair_t          w_head_next;

    // Operations are qualified so an illegal push/pop can never corrupt state
    assign full   = (r_count == c_count_full);
    assign empty  = (r_count == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign head   = r_head;
    assign count  = r_count;

    // Next head: a push into an empty (or emptying) FIFO bypasses the array,
    // a pop with more entries behind it loads the following slot, otherwise hold
    always_comb begin
        w_head_next = r_head;
        if (w_push && ((r_count == '0) || (w_pop && (r_count == c_count_one)))) begin
            w_head_next = push_data;
        end else if (w_pop && (r_count > c_count_one)) begin
            w_head_next = r_mem[r_rd_ptr + c_ptr_one];
        end
    end

    // Storage array; data path needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and head register; flush behaves like reset
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
            r_head <= w_head_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iir_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : iir_pair_packer
// Description : Groups a serial valid/ready sample stream into even/odd pairs
//               and buffers them in a small FWFT FIFO presented one pair per
//               cycle to the two-parallel IIR filter.
// Revision    : 1.0 - initial release
// ============================================================================
module iir_pair_packer
    import iir_pkg::*;
#(
    parameter int DATA_W = iir_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     flush,
    output logic [DATA_W-1:0]        x2k,
    output logic [DATA_W-1:0]        x2k1,
    output logic                     p_valid,
    input  logic                     p_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     pending
);

    // The pair type is fixed by the shared package, and pointer wrap relies
    // on a power-of-two depth
    if (DATA_W != iir_pkg::DATA_W) begin : g_width_check
        $error("iir_pair_packer: DATA_W must equal iir_pkg::DATA_W");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("iir_pair_packer: DEPTH must be a power of two >= 2");
    end

    phase_e   r_phase;
    phase_e   w_phase_next;
    sample_t  r_hold;

    logic     w_accept;
    logic     w_capture;
    logic     w_push;
    logic     w_pop;
    logic     w_full;
    logic     w_empty;
    pair_t    w_head;

    // Phase state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_EMPTY;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Handshake and phase sequencing. A full FIFO only stalls the odd sample;
    // flush keeps s_ready high so the source never sees a stall, and anything
    // offered during flush is dropped.
    always_comb begin
        w_phase_next = r_phase;
        w_capture    = 1'b0;
        w_push       = 1'b0;
        s_ready      = flush | (r_phase == PH_EMPTY) | ~w_full;
        w_accept     = s_valid & s_ready;
        if (flush) begin
            w_phase_next = PH_EMPTY;
        end else if (w_accept) begin
            case (r_phase)
                PH_EMPTY: begin
                    w_capture    = 1'b1;
                    w_phase_next = PH_HELD;
                end
                PH_HELD: begin
                    w_push       = 1'b1;
                    w_phase_next = PH_EMPTY;
                end
                default: w_phase_next = PH_EMPTY;
            endcase
        end
    end

    // Even-sample hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= '0;
        end else if (w_capture) begin
            r_hold <= s_data;
        end
    end

    // Pop on the filter-side handshake; the FIFO discards it under flush
    assign w_pop = p_valid & p_ready;

    iir_pair_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (w_push),
        .push_data (make_pair(r_hold, s_data)),
        .pop       (w_pop),
        .head      (w_head),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign p_valid = ~w_empty;
    assign x2k     = w_head.x2k;
    assign x2k1    = w_head.x2k1;
    assign pending = (r_phase == PH_HELD);

endmodule
`default_nettype wire

// File: tb/tb_iir_pair_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_iir_pair_packer
// Description : Self-checking bench for iir_pair_packer. A queue of expected
//               pairs is filled as odd samples are accepted and drained as the
//               filter side pops, alongside directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iir_pair_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        flush;
    logic [7:0]  x2k;
    logic [7:0]  x2k1;
    logic        p_valid;
    logic        p_ready;
    logic [2:0]  count;
    logic        pending;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_pop   = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic        m_phase;
    logic [7:0]  m_hold;
    logic [15:0] m_last;

    always #5 clk = ~clk;

    iir_pair_packer #(
        .DATA_W  (8),
        .DEPTH   (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .flush   (flush),
        .x2k     (x2k),
        .x2k1    (x2k1),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .count   (count),
        .pending (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase = 1'b0;
        m_hold  = 8'h00;
        m_last  = 16'h0000;
    endtask

    // Called just after a falling edge: drive, check outputs, advance model,
    // then wait past the rising edge to the next falling edge
    task automatic tick(input logic v, input logic [7:0] d, input logic pr, input logic fl);
        logic        exp_rdy;
        logic [15:0] exp_head;
        s_valid = v;
        s_data  = d;
        p_ready = pr;
        flush   = fl;
        #1;
        exp_rdy  = fl | !m_phase | (mq.size() != DEPTH);
        exp_head = (mq.size() != 0) ? mq[0] : m_last;
        chk("s_ready", 32'(s_ready), 32'(exp_rdy));
        chk("p_valid", 32'(p_valid), 32'(mq.size() != 0));
        chk("count",   32'(count),   32'(mq.size()));
        chk("pending", 32'(pending), 32'(m_phase));
        chk("x2k",     32'(x2k),     32'(exp_head[15:8]));
        chk("x2k1",    32'(x2k1),    32'(exp_head[7:0]));
        if (fl) begin
            mq.delete();
            m_phase = 1'b0;
            m_last  = 16'h0000;
        end else begin
            if ((mq.size() != 0) && pr) begin
                m_last = mq.pop_front();
                n_pop++;
            end
            if (v && exp_rdy) begin
                n_acc++;
                if (m_phase) begin
                    mq.push_back({m_hold, d});
                    m_phase = 1'b0;
                end else begin
                    m_hold  = d;
                    m_phase = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        flush   = 1'b0;
        p_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        for (int k = 0; k < 16 && mq.size() != 0; k++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Reset state
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_x2k",     32'({x2k, x2k1}), 32'd0);

        // Streaming with p_ready high
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream_cnt_le1", 32'(count <= 3'd1), 32'd1);
            if (i == 2) chk("stream_pair12", 32'({p_valid, x2k, x2k1}), 32'h10102);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        drain();

        // Backpressure
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(10 + i), 1'b0, 1'b0);
        #1;
        chk("bp_count4", 32'(count),   32'd4);
        chk("bp_ready1", 32'(s_ready), 32'd1);
        tick(1'b1, 8'd18, 1'b0, 1'b0);
        #1;
        chk("bp_pending", 32'(pending), 32'd1);
        chk("bp_ready0",  32'(s_ready), 32'd0);
        tick(1'b1, 8'd19, 1'b0, 1'b0);   // stalled
        tick(1'b1, 8'd19, 1'b1, 1'b0);   // pops (10,11), odd still stalled
        tick(1'b1, 8'd19, 1'b0, 1'b0);   // accepted, (18,19) at tail
        #1;
        chk("bp_count_after", 32'(count), 32'd4);
        chk("bp_head",        32'({x2k, x2k1}), 32'h0C0D);
        drain();

        // Simultaneous push and pop at count 2
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(20 + i), 1'b0, 1'b0);
        tick(1'b1, 8'd24, 1'b0, 1'b0);
        tick(1'b1, 8'd25, 1'b1, 1'b0);
        #1;
        chk("sim_count2", 32'(count), 32'd2);
        chk("sim_head",   32'({x2k, x2k1}), 32'h1617);
        drain();

        // Mid-pair flush
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(30 + i), 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        tick(1'b1, 8'hAA, 1'b0, 1'b1);
        #1;
        chk("fl_count",   32'(count),   32'd0);
        chk("fl_pending", 32'(pending), 32'd0);
        chk("fl_p_valid", 32'(p_valid), 32'd0);
        chk("fl_head0",   32'({x2k, x2k1}), 32'd0);
        tick(1'b1, 8'h40, 1'b0, 1'b0);
        tick(1'b1, 8'h41, 1'b0, 1'b0);
        #1;
        chk("fl_first_pair", 32'({p_valid, x2k, x2k1}), 32'h14041);
        drain();

        // Wrap-around with random handshakes
        n_acc = 0;
        n_pop = 0;
        for (int k = 0; k < 600 && n_acc < 6 * DEPTH; k++)
            tick(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        chk("wrap_accepts", 32'(n_acc), 32'(6 * DEPTH));
        drain();
        chk("wrap_pops", 32'(n_pop), 32'(3 * DEPTH));

        // Reset during operation discards held and queued data
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(50 + i), 1'b0, 1'b0);
        do_reset();
        #1;
        chk("rst2_count",   32'(count),   32'd0);
        chk("rst2_pending", 32'(pending), 32'd0);
        chk("rst2_head",    32'({x2k, x2k1}), 32'd0);
        tick(1'b1, 8'h61, 1'b0, 1'b0);
        tick(1'b1, 8'h62, 1'b0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
